// File: rtl/rx_pkg.sv
// Shared definitions for the rx_assembler receive stage:
// FSM state encoding and the default number of data symbols per frame.
package rx_pkg;

   localparam int SYMS_DEF = 4;

   typedef enum logic [2:0] {
      IDLE,
      HDR_REL,
      DATA,
      DATA_REL,
      DONE
   } rx_state_t;

endpackage

// File: rtl/sync2.sv
// 1-bit two-flop synchronizer, async active-high reset to 0.
// Ports: clk, reset, d (async input), q (synchronized output).
module sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rx_assembler.sv
// Receive stage for the two-bit Sender link: four-phase symbol handshake,
// assembles a header plus SYMS data symbols into a one-cycle frame result.
// Ports: clk, reset (async high); Bit0_In/Bit1_In/dt/comp from sender;
// ack to sender; rx_data/rx_ch/rx_up/rx_valid/rx_err/busy to control.
// Macro RX_SYNC_EN: pass dt and comp through 2-flop synchronizers.
import rx_pkg::*;

module rx_assembler #(
   parameter int SYMS = SYMS_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Bit0_In,
   input  logic              Bit1_In,
   input  logic              dt,
   input  logic              comp,
   output logic              ack,
   output logic [2*SYMS-1:0] rx_data,
   output logic              rx_ch,
   output logic              rx_up,
   output logic              rx_valid,
   output logic              rx_err,
   output logic              busy
);

   localparam int CW = (SYMS > 1) ? $clog2(SYMS) : 1;

   logic dt_s;
   logic comp_s;

`ifdef RX_SYNC_EN
   sync2 u_sync_dt (
      .clk   (clk),
      .reset (reset),
      .d     (dt),
      .q     (dt_s)
   );

   sync2 u_sync_comp (
      .clk   (clk),
      .reset (reset),
      .d     (comp),
      .q     (comp_s)
   );
`else
   assign dt_s   = dt;
   assign comp_s = comp;
`endif

   rx_state_t     state;
   logic [CW-1:0] cnt;
   logic          err;
   logic          last;
   logic          at_end;

   assign at_end = (cnt == CW'(SYMS - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         err      <= 1'b0;
         last     <= 1'b0;
         ack      <= 1'b0;
         busy     <= 1'b0;
         rx_data  <= '0;
         rx_ch    <= 1'b0;
         rx_up    <= 1'b0;
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
      end else begin
         // The result pulse is registered out of DONE, so it lands
         // in the first IDLE cycle and is cleared there.
         rx_valid <= 1'b0;
         rx_err   <= 1'b0;
         unique case (state)
            IDLE: begin
               ack <= 1'b0;
               if (dt_s) begin
                  rx_up   <= Bit1_In;
                  rx_ch   <= Bit0_In;
                  rx_data <= '0;
                  cnt     <= '0;
                  err     <= comp_s;
                  last    <= comp_s;
                  ack     <= 1'b1;
                  busy    <= 1'b1;
                  state   <= HDR_REL;
               end
            end
            HDR_REL: begin
               if (!dt_s) begin
                  ack   <= 1'b0;
                  state <= last ? DONE : DATA;
               end
            end
            DATA: begin
               if (dt_s) begin
                  rx_data[2*int'(cnt) +: 2] <= {Bit1_In, Bit0_In};
                  last  <= comp_s | at_end;
                  err   <= err | (comp_s != at_end);
                  ack   <= 1'b1;
                  state <= DATA_REL;
               end
            end
            DATA_REL: begin
               if (!dt_s) begin
                  ack <= 1'b0;
                  if (last) begin
                     state <= DONE;
                  end else begin
                     cnt   <= cnt + CW'(1);
                     state <= DATA;
                  end
               end
            end
            DONE: begin
               rx_valid <= 1'b1;
               rx_err   <= err;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
